gpio_ctrl_dbnc: RTL

//  Parametrised front-panel GPIO controller sitting between the FP GPIO pads and user logic.

---
 rtl/gpio_ctrl_dbnc.sv | 131 +++++++++++++
 1 files changed

// File: rtl/gpio_ctrl_dbnc.sv
// Front-panel GPIO controller: synchronised, debounced inputs with edge
// detection and sticky maskable interrupts, plus masked registered outputs.
module gpio_ctrl_dbnc #(
    parameter int GPIO_REG_WIDTH  = 12,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter logic [GPIO_REG_WIDTH-1:0] OUT_MASK    = 12'hD55,
    parameter logic [GPIO_REG_WIDTH-1:0] IN_MASK     = 12'h022,
    parameter logic [GPIO_REG_WIDTH-1:0] DDR_DEFAULT = 12'hD55
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [GPIO_REG_WIDTH-1:0] fp_gpio_in,
    output logic [GPIO_REG_WIDTH-1:0] fp_gpio_out,
    output logic [GPIO_REG_WIDTH-1:0] fp_gpio_ddr,
    input  logic [GPIO_REG_WIDTH-1:0] gpio_out,
    input  logic                      ddr_wr_en,
    input  logic [GPIO_REG_WIDTH-1:0] ddr_wr_data,
    output logic [GPIO_REG_WIDTH-1:0] gpio_in,
    output logic [GPIO_REG_WIDTH-1:0] edge_rise,
    output logic [GPIO_REG_WIDTH-1:0] edge_fall,
    input  logic [GPIO_REG_WIDTH-1:0] irq_rise_en,
    input  logic [GPIO_REG_WIDTH-1:0] irq_fall_en,
    input  logic [GPIO_REG_WIDTH-1:0] irq_clr,
    output logic [GPIO_REG_WIDTH-1:0] irq_status,
    output logic                      irq
);

    localparam int W     = GPIO_REG_WIDTH;
    localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (DEBOUNCE_CYCLES > 0) ?
                                            CNT_W'(DEBOUNCE_CYCLES - 1) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]     ZERO_W   = {W{1'b0}};

    logic [W-1:0]     sync_q [SYNC_STAGES];
    logic [W-1:0]     sync_s;
    logic [W-1:0]     stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [W];
    logic [CNT_W-1:0] cnt_d [W];
    logic [W-1:0]     edge_rise_q, edge_rise_d;
    logic [W-1:0]     edge_fall_q, edge_fall_d;
    logic [W-1:0]     irq_status_q, irq_status_d;
    logic             irq_q;
    logic [W-1:0]     ddr_q, ddr_d;
    logic [W-1:0]     out_q, out_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Metastability chain on the asynchronous pad inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= ZERO_W;
            end
        end else begin
            sync_q[0] <= fp_gpio_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Per-bit debounce: accept a new level only after it holds for the full window.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < W; i++) begin
            cnt_d[i] = {CNT_W{1'b0}};
            if (DEBOUNCE_CYCLES == 0) begin
                stable_d[i] = sync_s[i];
            end else if (sync_s[i] == stable_q[i]) begin
                cnt_d[i] = {CNT_W{1'b0}};
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync_s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Edge, interrupt, direction and output next-state logic.
    always_comb begin
        edge_rise_d  = stable_d & ~stable_q & IN_MASK;
        edge_fall_d  = ~stable_d & stable_q & IN_MASK;
        irq_status_d = (irq_status_q & ~irq_clr)
                     | (edge_rise_q & irq_rise_en)
                     | (edge_fall_q & irq_fall_en);
        if (ddr_wr_en) begin
            ddr_d = ddr_wr_data & OUT_MASK;
        end else begin
            ddr_d = ddr_q;
        end
        out_d = gpio_out & OUT_MASK & ddr_d;
    end

    // State registers; reset discards any in-progress debounce count.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q     <= ZERO_W;
            edge_rise_q  <= ZERO_W;
            edge_fall_q  <= ZERO_W;
            irq_status_q <= ZERO_W;
            irq_q        <= 1'b0;
            ddr_q        <= DDR_DEFAULT & OUT_MASK;
            out_q        <= ZERO_W;
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= {CNT_W{1'b0}};
            end
        end else begin
            stable_q     <= stable_d;
            edge_rise_q  <= edge_rise_d;
            edge_fall_q  <= edge_fall_d;
            irq_status_q <= irq_status_d;
            irq_q        <= |irq_status_q;
            ddr_q        <= ddr_d;
            out_q        <= out_d;
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign gpio_in     = stable_q & IN_MASK;
    assign edge_rise   = edge_rise_q;
    assign edge_fall   = edge_fall_q;
    assign irq_status  = irq_status_q;
    assign irq         = irq_q;
    assign fp_gpio_ddr = ddr_q;
    assign fp_gpio_out = out_q;

endmodule
